// File: rtl/uart_rx_cfg_pkg.sv
`timescale 1ns/1ps
// Shared types, limits and helpers for the configurable UART receiver.
package uart_rx_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_t;

   localparam int DATA_W_MIN  = 5;
   localparam int DATA_W_MAX  = 9;
   localparam int PRESC_W_MIN = 3;
   localparam int PRESC_MIN   = 4;

   // Wide enough to count start + 9 data + parity + 2 stop bits.
   localparam int BIT_CNT_W = 4;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Even parity wants an even number of ones over data plus parity bit,
   // odd parity an odd number, so the XOR of everything equals par_typ.
   function automatic logic parity_ok(input logic [DATA_W_MAX-1:0] data,
                                      input logic                  par_bit,
                                      input logic                  par_typ);
      return ((^data) ^ par_bit) == par_typ;
   endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
`timescale 1ns/1ps
// Line, configuration and consumer-side signals of the UART receiver.
interface uart_rx_cfg_if #(
   parameter int DATA_W  = 8,
   parameter int PRESC_W = 6
);

   logic               RX_IN;
   logic               PAR_EN;
   logic               PAR_TYP;
   logic               STOP2;
   logic [PRESC_W-1:0] Prescale;
   logic               data_ready;
   logic [DATA_W-1:0]  P_DATA;
   logic               data_valid;
   logic               Parity_error;
   logic               Framing_error;
   logic               Overrun_error;
   logic               Break_det;
   logic               busy;

   // The receiver drives the word and status; the line and consumer drive the rest.
   modport master (
      input  RX_IN, PAR_EN, PAR_TYP, STOP2, Prescale, data_ready,
      output P_DATA, data_valid, Parity_error, Framing_error,
             Overrun_error, Break_det, busy
   );

   modport slave (
      output RX_IN, PAR_EN, PAR_TYP, STOP2, Prescale, data_ready,
      input  P_DATA, data_valid, Parity_error, Framing_error,
             Overrun_error, Break_det, busy
   );

endinterface

// File: rtl/uart_rx_cfg_sampler.sv
`timescale 1ns/1ps
// Bit timing for the UART receiver: edge/bit counters and the sample strobe.
// Define UART_RX_MAJ_VOTE_EN for a 2-of-3 majority around the bit centre.
module uart_rx_sampler
   import uart_rx_cfg_pkg::*;
#(
   parameter int PRESC_W = 6
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 run,
   input  logic                 rx,
   input  logic [PRESC_W-1:0]   prescale,
   output logic                 stb,
   output logic                 bit_val,
   output logic                 wrap,
   output logic [BIT_CNT_W-1:0] bit_cnt
);

   localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

   logic [PRESC_W-1:0] cnt;
   logic [PRESC_W-1:0] half;
   logic [PRESC_W-1:0] dec_pt;

   assign half = prescale >> 1;
   assign wrap = run && (cnt == prescale - ONE);
   assign stb  = run && (cnt == dec_pt);

   // Counters sit at zero whenever no frame is in progress, so a frame
   // always starts counting from the first cycle of START.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt     <= '0;
         bit_cnt <= '0;
      end else if (!run) begin
         cnt     <= '0;
         bit_cnt <= '0;
      end else if (wrap) begin
         cnt     <= '0;
         bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end else begin
         cnt <= cnt + ONE;
      end
   end

`ifdef UART_RX_MAJ_VOTE_EN
   logic s_early;
   logic s_mid;

   assign dec_pt  = half + ONE;
   assign bit_val = (s_early & s_mid) | (s_early & rx) | (s_mid & rx);

   // Capture the two samples that precede the decision point.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s_early <= 1'b1;
         s_mid   <= 1'b1;
      end else begin
         if (run && (cnt == half - ONE)) s_early <= rx;
         if (run && (cnt == half))       s_mid   <= rx;
      end
   end
`else
   assign dec_pt  = half;
   assign bit_val = rx;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// Configurable UART receiver with parity, break, overrun and a valid/ready output.
// Define UART_RX_MAJ_VOTE_EN for majority-vote bit sampling.
module uart_rx_cfg
   import uart_rx_cfg_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PRESC_W = 6
) (
   input logic           CLK,
   input logic           RST,
   uart_rx_cfg_if.master bus
);

   localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_W);

   logic [1:0]           sync_q;
   logic                 rx_s;
   rx_state_t            state;
   logic                 par_en_l;
   logic                 par_typ_l;
   logic                 stop2_l;
   logic [PRESC_W-1:0]   presc_l;
   logic [DATA_W-1:0]    shift_q;
   logic                 par_bit_q;
   logic                 second_stop_q;
   logic                 run;
   logic                 stb;
   logic                 bit_val;
   logic                 wrap;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [DATA_W_MAX-1:0] data_ext;
   logic                 par_good;
   logic                 is_break;

   // Idle-high synchroniser so reset never looks like a start bit.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) sync_q <= 2'b11;
      else      sync_q <= {sync_q[0], bus.RX_IN};
   end

   assign rx_s = sync_q[1];
   assign run  = (state == ST_START) || (state == ST_DATA) ||
                 (state == ST_PARITY) || (state == ST_STOP);

   uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
      .CLK      (CLK),
      .RST      (RST),
      .run      (run),
      .rx       (rx_s),
      .prescale (presc_l),
      .stb      (stb),
      .bit_val  (bit_val),
      .wrap     (wrap),
      .bit_cnt  (bit_cnt)
   );

   always_comb begin
      data_ext                = '0;
      data_ext[DATA_W-1:0]    = shift_q;
      par_good                = parity_ok(data_ext, par_bit_q, par_typ_l);
      is_break                = (shift_q == '0) && !(par_en_l && par_bit_q);
   end

   // Frame FSM with registered status outputs. A new word loaded on the
   // same edge as a consumer handshake overrides the clear of data_valid.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state             <= ST_IDLE;
         par_en_l          <= 1'b0;
         par_typ_l         <= PAR_EVEN;
         stop2_l           <= 1'b0;
         presc_l           <= '0;
         shift_q           <= '0;
         par_bit_q         <= 1'b0;
         second_stop_q     <= 1'b0;
         bus.P_DATA        <= '0;
         bus.data_valid    <= 1'b0;
         bus.Parity_error  <= 1'b0;
         bus.Framing_error <= 1'b0;
         bus.Overrun_error <= 1'b0;
         bus.Break_det     <= 1'b0;
         bus.busy          <= 1'b0;
      end else begin
         bus.Parity_error  <= 1'b0;
         bus.Framing_error <= 1'b0;
         bus.Overrun_error <= 1'b0;
         bus.Break_det     <= 1'b0;
         if (bus.data_valid && bus.data_ready) bus.data_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               bus.busy <= 1'b0;
               if (!rx_s) begin
                  state         <= ST_START;
                  par_en_l      <= bus.PAR_EN;
                  par_typ_l     <= bus.PAR_TYP;
                  stop2_l       <= bus.STOP2;
                  presc_l       <= bus.Prescale;
                  par_bit_q     <= 1'b0;
                  second_stop_q <= 1'b0;
               end
            end

            ST_START: begin
               if (stb && bit_val) begin
                  state    <= ST_IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  bus.busy <= 1'b1;
                  if (wrap) state <= ST_DATA;
               end
            end

            ST_DATA: begin
               bus.busy <= 1'b1;
               if (stb) shift_q <= {bit_val, shift_q[DATA_W-1:1]};
               if (wrap && (bit_cnt == LAST_DATA_BIT))
                  state <= par_en_l ? ST_PARITY : ST_STOP;
            end

            ST_PARITY: begin
               bus.busy <= 1'b1;
               if (stb)  par_bit_q <= bit_val;
               if (wrap) state     <= ST_STOP;
            end

            // The frame ends at the last stop sample so a slightly early
            // next start bit is still seen from IDLE.
            ST_STOP: begin
               bus.busy <= 1'b1;
               if (stb) begin
                  if (!bit_val) begin
                     state <= ST_WAIT_HIGH;
                     if (!second_stop_q && is_break) begin
                        bus.Break_det <= 1'b1;
                     end else begin
                        bus.Framing_error <= 1'b1;
                        bus.Parity_error  <= par_en_l && !par_good;
                     end
                  end else if (stop2_l && !second_stop_q) begin
                     second_stop_q <= 1'b1;
                  end else begin
                     state    <= ST_IDLE;
                     bus.busy <= 1'b0;
                     if (par_en_l && !par_good) begin
                        bus.Parity_error <= 1'b1;
                     end else if (bus.data_valid && !bus.data_ready) begin
                        bus.Overrun_error <= 1'b1;
                     end else begin
                        bus.P_DATA     <= shift_q;
                        bus.data_valid <= 1'b1;
                     end
                  end
               end
            end

            ST_WAIT_HIGH: begin
               if (rx_s) begin
                  state    <= ST_IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  bus.busy <= 1'b1;
               end
            end

            default: begin
               state    <= ST_IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// Directed self-checking bench for uart_rx_cfg at Prescale 8, DATA_W 8.
module tb_uart_rx_cfg;
   import uart_rx_cfg_pkg::*;

   localparam int DATA_W  = 8;
   localparam int PRESC_W = 6;
   localparam int PRESC   = 8;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   uart_rx_cfg_if #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) bus ();

   uart_rx_cfg #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // 200 MHz clock.
   always #2.5 CLK = ~CLK;

   int   nCompared   = 0;
   int   nMismatched = 0;
   int   parCnt = 0, frmCnt = 0, ovrCnt = 0, brkCnt = 0, dvRise = 0;
   int   parBase = 0, frmBase = 0, ovrBase = 0, brkBase = 0, dvBase = 0;
   logic dvPrev = 1'b0;

   // Pulse and data_valid-rise counters; a stretched pulse counts twice.
   always @(negedge CLK) begin
      if (bus.Parity_error)  parCnt++;
      if (bus.Framing_error) frmCnt++;
      if (bus.Overrun_error) ovrCnt++;
      if (bus.Break_det)     brkCnt++;
      if (bus.data_valid && !dvPrev) dvRise++;
      dvPrev = bus.data_valid;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic takeSnapshot();
      parBase = parCnt;
      frmBase = frmCnt;
      ovrBase = ovrCnt;
      brkBase = brkCnt;
      dvBase  = dvRise;
   endtask

   // Drives one frame starting now; the line is left at the last bit's level.
   task automatic applyStimulus(input logic [7:0] d, input logic usePar, input logic pBit,
                                input int nStop, input logic firstStop);
      bus.RX_IN = 1'b0;
      repeat (PRESC) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         bus.RX_IN = d[i];
         repeat (PRESC) @(negedge CLK);
      end
      if (usePar) begin
         bus.RX_IN = pBit;
         repeat (PRESC) @(negedge CLK);
      end
      for (int s = 0; s < nStop; s++) begin
         bus.RX_IN = (s == 0) ? firstStop : 1'b1;
         repeat (PRESC) @(negedge CLK);
      end
   endtask

   initial begin
      bus.RX_IN      = 1'b1;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = PAR_EVEN;
      bus.STOP2      = 1'b0;
      bus.Prescale   = PRESC_W'(PRESC);
      bus.data_ready = 1'b0;
      RST            = 1'b0;
      idleCycles(3);

      checkOutput("rst_pdata",   32'(bus.P_DATA),        32'h0);
      checkOutput("rst_valid",   32'(bus.data_valid),    32'h0);
      checkOutput("rst_parity",  32'(bus.Parity_error),  32'h0);
      checkOutput("rst_framing", 32'(bus.Framing_error), 32'h0);
      checkOutput("rst_overrun", 32'(bus.Overrun_error), 32'h0);
      checkOutput("rst_break",   32'(bus.Break_det),     32'h0);
      checkOutput("rst_busy",    32'(bus.busy),          32'h0);
      RST = 1'b1;
      idleCycles(4);

      // 0x93 has four ones, so odd parity needs a parity bit of 1.
      bus.PAR_EN  = 1'b1;
      bus.PAR_TYP = PAR_ODD;
      takeSnapshot();
      applyStimulus(8'h93, 1'b1, 1'b1, 1, 1'b1);
      idleCycles(2);
      checkOutput("odd_pdata",   32'(bus.P_DATA),     32'h93);
      checkOutput("odd_valid",   32'(bus.data_valid), 32'h1);
      checkOutput("odd_parerr",  parCnt - parBase,    32'h0);
      checkOutput("odd_frmerr",  frmCnt - frmBase,    32'h0);
      checkOutput("odd_busy",    32'(bus.busy),       32'h0);
      bus.data_ready = 1'b1;
      @(negedge CLK);
      bus.data_ready = 1'b0;
      checkOutput("odd_consumed", 32'(bus.data_valid), 32'h0);

      // 0x0F with even parity wants bit 0; sending 1 is a parity error.
      bus.PAR_TYP = PAR_EVEN;
      bus.STOP2   = 1'b1;
      takeSnapshot();
      applyStimulus(8'h0F, 1'b1, 1'b1, 2, 1'b1);
      idleCycles(2);
      checkOutput("perr_pulse", parCnt - parBase,    32'h1);
      checkOutput("perr_pdata", 32'(bus.P_DATA),     32'h93);
      checkOutput("perr_novld", dvRise - dvBase,     32'h0);

      // Back-to-back frames with the consumer always ready.
      bus.data_ready = 1'b1;
      bus.PAR_TYP    = PAR_ODD;
      bus.STOP2      = 1'b0;
      takeSnapshot();
      applyStimulus(8'h93, 1'b1, 1'b1, 1, 1'b1);
      bus.PAR_TYP = PAR_EVEN;
      bus.STOP2   = 1'b1;
      applyStimulus(8'h0F, 1'b1, 1'b0, 2, 1'b1);
      idleCycles(2);
      checkOutput("b2b_pdata",   32'(bus.P_DATA),     32'h0F);
      checkOutput("b2b_words",   dvRise - dvBase,     32'h2);
      checkOutput("b2b_parerr",  parCnt - parBase,    32'h0);
      checkOutput("b2b_overrun", ovrCnt - ovrBase,    32'h0);
      checkOutput("b2b_valid",   32'(bus.data_valid), 32'h0);

      // Stop bit 0 on 0x55, line held low afterwards.
      bus.data_ready = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.STOP2      = 1'b0;
      takeSnapshot();
      applyStimulus(8'h55, 1'b0, 1'b0, 1, 1'b0);
      idleCycles(4);
      checkOutput("frm_pulse", frmCnt - frmBase, 32'h1);
      checkOutput("frm_nobrk", brkCnt - brkBase, 32'h0);
      checkOutput("frm_busy",  32'(bus.busy),    32'h1);
      checkOutput("frm_novld", dvRise - dvBase,  32'h0);
      bus.RX_IN = 1'b1;
      idleCycles(6);
      checkOutput("frm_idle",  32'(bus.busy),    32'h0);
      applyStimulus(8'hA5, 1'b0, 1'b0, 1, 1'b1);
      idleCycles(2);
      checkOutput("frm_next_pdata", 32'(bus.P_DATA),     32'hA5);
      checkOutput("frm_next_valid", 32'(bus.data_valid), 32'h1);
      bus.data_ready = 1'b1;
      @(negedge CLK);
      bus.data_ready = 1'b0;

      // Line low for 12 bit times.
      takeSnapshot();
      bus.RX_IN = 1'b0;
      idleCycles(12 * PRESC);
      bus.RX_IN = 1'b1;
      idleCycles(16);
      checkOutput("brk_pulse", brkCnt - brkBase, 32'h1);
      checkOutput("brk_nofrm", frmCnt - frmBase, 32'h0);
      checkOutput("brk_novld", dvRise - dvBase,  32'h0);
      checkOutput("brk_pdata", 32'(bus.P_DATA),  32'hA5);
      checkOutput("brk_busy",  32'(bus.busy),    32'h0);

      // Second word arrives while the first is still unconsumed.
      takeSnapshot();
      applyStimulus(8'h11, 1'b0, 1'b0, 1, 1'b1);
      idleCycles(4);
      applyStimulus(8'h22, 1'b0, 1'b0, 1, 1'b1);
      idleCycles(2);
      checkOutput("ovr_pulse", ovrCnt - ovrBase,    32'h1);
      checkOutput("ovr_pdata", 32'(bus.P_DATA),     32'h11);
      checkOutput("ovr_valid", 32'(bus.data_valid), 32'h1);

      // Completion edge is 79.5 cycles after the start falling edge.
      takeSnapshot();
      fork
         applyStimulus(8'h22, 1'b0, 1'b0, 1, 1'b1);
         begin
            idleCycles(79);
            bus.data_ready = 1'b1;
            @(negedge CLK);
            bus.data_ready = 1'b0;
         end
      join
      idleCycles(2);
      checkOutput("rdy_pdata",   32'(bus.P_DATA),     32'h22);
      checkOutput("rdy_valid",   32'(bus.data_valid), 32'h1);
      checkOutput("rdy_overrun", ovrCnt - ovrBase,    32'h0);

      // Three-cycle low glitch must be rejected at the start sample.
      takeSnapshot();
      bus.RX_IN = 1'b0;
      idleCycles(3);
      bus.RX_IN = 1'b1;
      idleCycles(12);
      checkOutput("glitch_busy",  32'(bus.busy),    32'h0);
      checkOutput("glitch_novld", dvRise - dvBase,  32'h0);
      checkOutput("glitch_nofrm", frmCnt - frmBase, 32'h0);
      checkOutput("glitch_nobrk", brkCnt - brkBase, 32'h0);
      checkOutput("glitch_pdata", 32'(bus.P_DATA),  32'h22);

      // Reset pulse during data bit 4 of 0xF0; the remaining bits are all 1.
      fork
         applyStimulus(8'hF0, 1'b0, 1'b0, 1, 1'b1);
         begin
            idleCycles(44);
            checkOutput("midrst_busy_before", 32'(bus.busy), 32'h1);
            RST = 1'b0;
            @(negedge CLK);
            checkOutput("midrst_pdata", 32'(bus.P_DATA),     32'h0);
            checkOutput("midrst_valid", 32'(bus.data_valid), 32'h0);
            checkOutput("midrst_busy",  32'(bus.busy),       32'h0);
            RST = 1'b1;
         end
      join
      idleCycles(4);
      takeSnapshot();
      applyStimulus(8'h3C, 1'b0, 1'b0, 1, 1'b1);
      idleCycles(2);
      checkOutput("post_rst_pdata", 32'(bus.P_DATA),     32'h3C);
      checkOutput("post_rst_valid", 32'(bus.data_valid), 32'h1);
      checkOutput("post_rst_words", dvRise - dvBase,     32'h1);
      checkOutput("post_rst_nofrm", frmCnt - frmBase,    32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
